// File: rtl/BasicParam.sv
// Shared address-geometry helpers used to size caches.
// Keeps tag width arithmetic in a single place.
package BasicParam;

    // Tag bits left over after the line offset and index fields.
    function automatic int BASIC_TAG_WIDTH(
        input int max_mem,
        input int cache_widthe,
        input int cache_deepthe
    );
        return max_mem - cache_widthe - cache_deepthe;
    endfunction

endpackage

// File: rtl/CacheParam.sv
// Instruction-cache sizing helpers and the refill FSM state type.
// Everything is derived from the top-level geometry parameters.
package CacheParam;

    import BasicParam::*;

    function automatic int tag_w(
        input int max_mem,
        input int cache_widthe,
        input int cache_deepthe
    );
        return BASIC_TAG_WIDTH(max_mem, cache_widthe, cache_deepthe);
    endfunction

    function automatic int idx_w(input int cache_deepthe);
        return cache_deepthe;
    endfunction

    function automatic int line_bits(input int cache_widthe);
        return 8 << cache_widthe;
    endfunction

    function automatic int beats(
        input int cache_widthe,
        input int bus_bits
    );
        return line_bits(cache_widthe) / bus_bits;
    endfunction

    // Beat counter needs at least one bit even for single-beat lines.
    function automatic int cnt_w(
        input int cache_widthe,
        input int bus_bits
    );
        int n;
        n = beats(cache_widthe, bus_bits);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        MISS_REQ  = 2'd2,
        MISS_DATA = 2'd3
    } fill_state_e;

endpackage

// File: rtl/icache_line_ram.sv
// Line data storage: beat-granular write port and
// combinational 32-bit word read port.
module icache_line_ram #(
    parameter int LINES     = 64,
    parameter int LINE_BITS = 256,
    parameter int BUS_BITS  = 64,
    parameter int IDX_W     = 6,
    parameter int CNT_W     = 2,
    parameter int WSEL_W    = 3
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [CNT_W-1:0]    wr_beat,
    input  logic [BUS_BITS-1:0] wr_data,
    input  logic [IDX_W-1:0]    rd_idx,
    input  logic [WSEL_W-1:0]   rd_wsel,
    output logic [31:0]         rd_word
);

    logic [LINE_BITS-1:0] line_q [LINES];

    // Store one refill beat into its slice of the selected line.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_q[wr_idx][int'(wr_beat) * BUS_BITS +: BUS_BITS] <= wr_data;
        end
    end

    assign rd_word = line_q[rd_idx][int'(rd_wsel) * 32 +: 32];

endmodule

// File: rtl/icache_line_fill.sv
// Direct-mapped read-only instruction cache with a
// line-refill state machine between fetch and memory bus.
module icache_line_fill
    import CacheParam::*;
#(
    parameter int MAX_MEM       = 32,
    parameter int CACHE_WIDTHE  = 5,
    parameter int CACHE_DEEPTHE = 6,
    parameter int BUS_BITS      = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [MAX_MEM-1:0]  req_addr,
    output logic                resp_valid,
    output logic [31:0]         resp_data,
    input  logic                flush,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [MAX_MEM-1:0]  mem_req_addr,
    input  logic                mem_resp_valid,
    input  logic [BUS_BITS-1:0] mem_resp_data
);

    localparam int TAG_W     = tag_w(MAX_MEM, CACHE_WIDTHE, CACHE_DEEPTHE);
    localparam int IDX_W     = idx_w(CACHE_DEEPTHE);
    localparam int LINES     = 1 << IDX_W;
    localparam int LINE_BITS = line_bits(CACHE_WIDTHE);
    localparam int BEATS     = beats(CACHE_WIDTHE, BUS_BITS);
    localparam int CNT_W     = cnt_w(CACHE_WIDTHE, BUS_BITS);
    localparam int WSEL_W    = (CACHE_WIDTHE > 2) ? CACHE_WIDTHE - 2 : 1;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    fill_state_e          state_q, state_d;
    logic [MAX_MEM-1:2]   addr_q, addr_d;
    logic [LINES-1:0]     valid_q, valid_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [31:0]          resp_data_q, resp_data_d;
    logic [TAG_W-1:0]     tag_q [LINES];

    logic [TAG_W-1:0]     cur_tag;
    logic [IDX_W-1:0]     cur_idx;
    logic [WSEL_W-1:0]    cur_wsel;
    logic                 hit;
    logic                 beat_wr;
    logic                 last_beat;
    logic [31:0]          rd_word;
    logic                 unused_addr_lsb;

    // Byte lanes inside a word never matter for a word fetch.
    assign unused_addr_lsb = ^req_addr[1:0];

    assign cur_tag = addr_q[MAX_MEM-1 -: TAG_W];
    assign cur_idx = addr_q[CACHE_WIDTHE+IDX_W-1 : CACHE_WIDTHE];

    if (CACHE_WIDTHE > 2) begin : g_wsel
        assign cur_wsel = addr_q[CACHE_WIDTHE-1:2];
    end else begin : g_wsel_one
        assign cur_wsel = '0;
    end

    assign hit       = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
    assign beat_wr   = (state_q == MISS_DATA) && mem_resp_valid;
    assign last_beat = beat_wr && (cnt_q == LAST_BEAT);

    assign req_ready     = (state_q == IDLE);
    assign mem_req_valid = (state_q == MISS_REQ);
    assign mem_req_addr  = {cur_tag, cur_idx, {CACHE_WIDTHE{1'b0}}};
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;

    icache_line_ram #(
        .LINES     (LINES),
        .LINE_BITS (LINE_BITS),
        .BUS_BITS  (BUS_BITS),
        .IDX_W     (IDX_W),
        .CNT_W     (CNT_W),
        .WSEL_W    (WSEL_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (beat_wr),
        .wr_idx  (cur_idx),
        .wr_beat (cnt_q),
        .wr_data (mem_resp_data),
        .rd_idx  (cur_idx),
        .rd_wsel (cur_wsel),
        .rd_word (rd_word)
    );

    // Next state: accept, look up, request the line, collect beats, replay.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr[MAX_MEM-1:2];
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = rd_word;
                    state_d      = IDLE;
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = MISS_DATA;
                end
            end
            MISS_DATA: begin
                if (beat_wr) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = LOOKUP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Flush wipes everything first; a completing refill still lands valid.
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end
        if (last_beat) begin
            valid_d[cur_idx] = 1'b1;
        end
    end

    // Tag is written together with the final beat of the line.
    always_ff @(posedge clk) begin
        if (last_beat) begin
            tag_q[cur_idx] <= cur_tag;
        end
    end

    // Control state, valid bits and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            valid_q      <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_icache_line_fill.sv
// Self-checking bench for icache_line_fill: directed vector table,
// reset-during-refill sequence and randomized fetches vs a reference model.
module tb_icache_line_fill;

    localparam int BEATS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        flush = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;

    int errors = 0;
    int checks = 0;

    icache_line_fill dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          missed;
        logic [31:0] maddr;
        logic [31:0] data;
        int          lat;
        int          pulses;
        int          hs;
        int          gaps;
        bit          stable;
        bit          tmo;
    } res_t;

    typedef struct {
        logic [31:0] addr;
        int          rd;
        int          gap;
        bit          pre_fl;
        bit          fl_lk;
        int          fl_beat;
        bit          exp_miss;
        logic [31:0] exp_data;
    } vec_t;

    logic [31:0] ovr [logic [31:0]];
    vec_t        vt [$];
    bit          mv [64];
    int          mt [64];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (ovr.exists(w)) return ovr[w];
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [63:0] beat(input logic [31:0] line, input int b);
        logic [31:0] base;
        base = line + 32'(8 * b);
        return {mem_word(base + 32'd4), mem_word(base)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input int rd, input int gap,
                         input bit pre_fl, input bit fl_lk, input int fl_beat,
                         output res_t r);
        int          wait_cnt;
        int          b;
        int          cyc;
        bit          in_beats;
        logic [31:0] line;
        r = '{default: 0};
        r.stable = 1'b1;
        line = '0;
        if (pre_fl) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
        end
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        req_valid = 1'b1;
        req_addr  = a;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        r.lat = 1;
        wait_cnt = 0;
        b = 0;
        in_beats = 1'b0;
        if (fl_lk) flush = 1'b1;
        while (r.lat < 200) begin
            if (resp_valid) begin
                r.pulses = 1;
                r.data   = resp_data;
                break;
            end
            if (r.lat > 1) flush = 1'b0;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (in_beats && b < BEATS) begin
                if (gap == 0 || $urandom_range(0, 99) >= gap) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = beat(line, b);
                    if (b == fl_beat) flush = 1'b1;
                    b++;
                end else begin
                    r.gaps++;
                end
            end
            if (mem_req_valid) begin
                if (!r.missed) begin
                    r.missed = 1'b1;
                    r.maddr  = mem_req_addr;
                    line     = mem_req_addr;
                end else if (mem_req_addr !== r.maddr) begin
                    r.stable = 1'b0;
                end
                if (wait_cnt >= rd) begin
                    mem_req_ready = 1'b1;
                    r.hs++;
                    in_beats = 1'b1;
                end
                wait_cnt++;
            end else if (r.missed && !in_beats) begin
                r.stable = 1'b0;
            end
            @(posedge clk); #1;
            r.lat++;
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        flush          = 1'b0;
        if (r.pulses == 0) begin
            r.tmo = 1'b1;
        end else begin
            @(posedge clk); #1;
            if (resp_valid) r.pulses++;
        end
    endtask

    task automatic run_check(input string nm, input logic [31:0] a,
                             input int rd, input int gap, input bit pre_fl,
                             input bit fl_lk, input int fl_beat,
                             input bit em, input logic [31:0] ed);
        res_t r;
        fetch(a, rd, gap, pre_fl, fl_lk, fl_beat, r);
        chk({nm, " timeout"}, 32'(r.tmo), 32'd0);
        chk({nm, " miss"}, 32'(r.missed), 32'(em));
        chk({nm, " handshakes"}, r.hs, em ? 1 : 0);
        if (em) begin
            chk({nm, " mem_req_addr"}, r.maddr, a & 32'hFFFF_FFE0);
            chk({nm, " req held"}, 32'(r.stable), 32'd1);
        end
        chk({nm, " data"}, r.data, ed);
        chk({nm, " pulses"}, r.pulses, 1);
        chk({nm, " latency"}, r.lat,
            em ? 4 + BEATS + rd + r.gaps : 2);
    endtask

    task automatic add_vec(input logic [31:0] a, input int rd, input int gap,
                           input bit pre_fl, input bit fl_lk, input int fl_beat,
                           input bit em);
        vec_t v;
        v.addr = a; v.rd = rd; v.gap = gap;
        v.pre_fl = pre_fl; v.fl_lk = fl_lk; v.fl_beat = fl_beat;
        v.exp_miss = em; v.exp_data = mem_word(a);
        vt.push_back(v);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
        chk({nm, " resp_valid"}, 32'(resp_valid), 32'd0);
        chk({nm, " mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          idx;
        int          tg;
        bit          em;
        int          rd;
        int          gap;
        bit          pf;
        bit          fl;
        int          fb;

        ovr[32'h0000_1008] = 32'h1111_1111;
        ovr[32'h0000_100C] = 32'h2222_2222;

        add_vec(32'h0000_1008, 0, 0,  0, 0, -1, 1);
        add_vec(32'h0000_100C, 0, 0,  0, 0, -1, 0);
        add_vec(32'h0000_1808, 0, 0,  0, 0, -1, 1);
        add_vec(32'h0000_1008, 0, 0,  0, 0, -1, 1);
        add_vec(32'h0000_2014, 5, 50, 0, 0, -1, 1);
        add_vec(32'h0000_1008, 0, 0,  0, 0, -1, 1);
        add_vec(32'h0000_1008, 0, 0,  1, 0, -1, 1);
        add_vec(32'h0000_0024, 0, 0,  0, 0, -1, 1);
        add_vec(32'h0000_1808, 2, 0,  0, 0, -1, 1);
        add_vec(32'h0000_1008, 0, 0,  0, 0,  2, 1);
        add_vec(32'h0000_1008, 0, 0,  0, 0, -1, 0);
        add_vec(32'h0000_0028, 0, 0,  0, 0, -1, 1);
        add_vec(32'h0000_0044, 0, 0,  0, 0, -1, 1);
        add_vec(32'h0000_1808, 0, 30, 0, 0,  3, 1);
        add_vec(32'h0000_0048, 0, 0,  0, 0, -1, 1);
        add_vec(32'h0000_180C, 0, 0,  0, 0, -1, 0);
        add_vec(32'h0000_1810, 0, 0,  0, 1, -1, 0);
        add_vec(32'h0000_1814, 0, 0,  0, 0, -1, 1);

        #1 rst_n = 1'b0;
        #2;
        chk_idle_outputs("reset");
        chk("reset resp_data", resp_data, 32'd0);
        chk("reset mem_req_addr", mem_req_addr, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vt.size(); i++) begin
            run_check($sformatf("vec%0d", i), vt[i].addr, vt[i].rd, vt[i].gap,
                      vt[i].pre_fl, vt[i].fl_lk, vt[i].fl_beat,
                      vt[i].exp_miss, vt[i].exp_data);
        end

        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0000_1008;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst seq mem_req_valid", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = beat(32'h0000_1000, b);
            @(posedge clk); #1;
        end
        mem_resp_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_idle_outputs("midfill reset");
        chk("midfill reset resp_data", resp_data, 32'd0);
        chk("midfill reset mem_req_addr", mem_req_addr, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = {$urandom, $urandom};
            @(posedge clk); #1;
            chk_idle_outputs($sformatf("stray beat%0d", k));
        end
        mem_resp_valid = 1'b0;
        model_clear();
        run_check("post reset", 32'h0000_1008, 0, 0, 0, 0, -1, 1,
                  32'h1111_1111);
        mv[0] = 1'b1;
        mt[0] = 2;

        for (int n = 0; n < 60; n++) begin
            a   = (32'($urandom_range(0, 3)) << 11) |
                  (32'($urandom_range(0, 3)) << 5) |
                  (32'($urandom_range(0, 7)) << 2) |
                  32'($urandom_range(0, 3));
            rd  = $urandom_range(0, 3);
            gap = ($urandom_range(0, 1) == 1) ? 30 : 0;
            pf  = ($urandom_range(0, 9) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            fb  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1;
            idx = int'(a >> 5) % 64;
            tg  = int'(a >> 11);
            if (pf) model_clear();
            em = !(mv[idx] && mt[idx] == tg);
            if (fl) model_clear();
            if (em) begin
                if (fb >= 0) model_clear();
                mv[idx] = 1'b1;
                mt[idx] = tg;
            end
            run_check($sformatf("rand%0d", n), a, rd, gap, pf, fl, fb, em,
                      mem_word(a));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
